// File: rtl/innings_controller.sv
// Two-innings cricket scoreboard: counts runs/wickets/overs/balls per innings,
// tracks the innings-1 target and decides winner or tie once the chase ends.
`timescale 1ns/1ps
module innings_controller #(
  parameter int MAX_OVERS = 20
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       ball_valid,
  input  logic [2:0] runs_in,
  input  logic       wicket_in,
  input  logic       extra_in,
  input  logic       next_inning,
  input  logic       new_game,
  output logic [7:0] binaryruns,
  output logic [3:0] binarywickets,
  output logic [4:0] overs,
  output logic [2:0] balls,
  output logic       inningOver,
  output logic       gameOver,
  output logic       winner,
  output logic       tie
);

  localparam logic [4:0] MAX_OV = 5'(MAX_OVERS);

  typedef enum logic [1:0] {INN1, BREAK, INN2, DONE} state_t;

  state_t     state_q;
  logic [7:0] runs_q, target_q;
  logic [3:0] wkts_q;
  logic [4:0] overs_q;
  logic [2:0] balls_q;
  logic       inn_over_q, game_over_q, winner_q, tie_q;

  // Counter values that would result from the delivery on the inputs now.
  logic [2:0] runs_clamp;
  logic [3:0] runs_add;
  logic [8:0] runs_sum;
  logic [7:0] runs_d;
  logic [3:0] wkts_d;
  logic [4:0] overs_d;
  logic [2:0] balls_d;
  logic       limit_d, chase_d;

  always_comb begin
    runs_clamp = (runs_in > 3'd6) ? 3'd6 : runs_in;
    runs_add   = {1'b0, runs_clamp} + {3'b000, extra_in};
    runs_sum   = {1'b0, runs_q} + {5'b00000, runs_add};
    runs_d     = runs_sum[8] ? 8'hFF : runs_sum[7:0];
    wkts_d     = wkts_q + {3'b000, wicket_in};
    overs_d    = overs_q;
    balls_d    = balls_q;
    if (!extra_in) begin
      if (balls_q == 3'd5) begin
        balls_d = 3'd0;
        overs_d = overs_q + 5'd1;
      end else begin
        balls_d = balls_q + 3'd1;
      end
    end
    limit_d = (wkts_d == 4'd10) || (overs_d == MAX_OV);
    chase_d = runs_d > target_q;
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state_q     <= INN1;
      runs_q      <= '0;
      target_q    <= '0;
      wkts_q      <= '0;
      overs_q     <= '0;
      balls_q     <= '0;
      inn_over_q  <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      tie_q       <= 1'b0;
    end else begin
      case (state_q)
        INN1: begin
          if (ball_valid) begin
            runs_q  <= runs_d;
            wkts_q  <= wkts_d;
            overs_q <= overs_d;
            balls_q <= balls_d;
            if (limit_d) begin
              state_q    <= BREAK;
              inn_over_q <= 1'b1;
            end
          end
        end
        BREAK: begin
          if (next_inning) begin
            state_q    <= INN2;
            target_q   <= runs_q;
            runs_q     <= '0;
            wkts_q     <= '0;
            overs_q    <= '0;
            balls_q    <= '0;
            inn_over_q <= 1'b0;
          end
        end
        INN2: begin
          if (ball_valid) begin
            runs_q  <= runs_d;
            wkts_q  <= wkts_d;
            overs_q <= overs_d;
            balls_q <= balls_d;
            // A successful chase wins even if the same ball also ends the innings.
            if (chase_d) begin
              state_q     <= DONE;
              game_over_q <= 1'b1;
              winner_q    <= 1'b1;
              tie_q       <= 1'b0;
            end else if (limit_d) begin
              state_q     <= DONE;
              game_over_q <= 1'b1;
              winner_q    <= 1'b0;
              tie_q       <= (runs_d == target_q);
            end
          end
        end
        DONE: begin
          if (new_game) begin
            state_q     <= INN1;
            runs_q      <= '0;
            target_q    <= '0;
            wkts_q      <= '0;
            overs_q     <= '0;
            balls_q     <= '0;
            inn_over_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            tie_q       <= 1'b0;
          end
        end
        default: state_q <= INN1;
      endcase
    end
  end

  assign binaryruns    = runs_q;
  assign binarywickets = wkts_q;
  assign overs         = overs_q;
  assign balls         = balls_q;
  assign inningOver    = inn_over_q;
  assign gameOver      = game_over_q;
  assign winner        = winner_q;
  assign tie           = tie_q;

endmodule

// File: tb/tb_innings_controller.sv
// Scoreboard bench: every stimulus cycle pushes the model's expected outputs,
// a monitor pops one entry after each rising edge and compares.
`timescale 1ns/1ps
module tb_innings_controller;
  localparam int MAXO = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ball_valid = 1'b0, wicket_in = 1'b0, extra_in = 1'b0;
  logic       next_inning = 1'b0, new_game = 1'b0;
  logic [2:0] runs_in = 3'd0;
  logic [7:0] binaryruns;
  logic [3:0] binarywickets;
  logic [4:0] overs;
  logic [2:0] balls;
  logic       inningOver, gameOver, winner, tie;

  innings_controller #(.MAX_OVERS(MAXO)) dut (
    .clk_fpga(clk), .reset(reset), .ball_valid(ball_valid), .runs_in(runs_in),
    .wicket_in(wicket_in), .extra_in(extra_in), .next_inning(next_inning),
    .new_game(new_game), .binaryruns(binaryruns), .binarywickets(binarywickets),
    .overs(overs), .balls(balls), .inningOver(inningOver), .gameOver(gameOver),
    .winner(winner), .tie(tie));

  always #5 clk = ~clk;

  typedef struct {
    int    r, w, o, b;
    bit    io, go, win, tie;
    string lbl;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0;

  // Reference model: phase 0=first innings, 1=break, 2=chase, 3=finished.
  int m_phase = 0, m_runs = 0, m_wk = 0, m_legal = 0, m_target = 0;
  bit m_win = 0, m_tie = 0;

  task automatic model_clear();
    m_phase = 0; m_runs = 0; m_wk = 0; m_legal = 0; m_target = 0;
    m_win = 0; m_tie = 0;
  endtask

  task automatic model(input bit bv, input int r, input bit wk, input bit ex,
                       input bit ni, input bit ng, input bit rst);
    int add;
    if (rst) begin model_clear(); return; end
    if ((m_phase == 0 || m_phase == 2) && bv) begin
      add = ((r > 6) ? 6 : r) + (ex ? 1 : 0);
      m_runs = (m_runs + add > 255) ? 255 : m_runs + add;
      if (wk) m_wk++;
      if (!ex) m_legal++;
      if (m_phase == 2 && m_runs > m_target) begin
        m_phase = 3; m_win = 1; m_tie = 0;
      end else if (m_wk == 10 || m_legal / 6 == MAXO) begin
        if (m_phase == 0) m_phase = 1;
        else begin m_phase = 3; m_win = 0; m_tie = (m_runs == m_target); end
      end
    end else if (m_phase == 1 && ni) begin
      m_phase = 2; m_target = m_runs; m_runs = 0; m_wk = 0; m_legal = 0;
    end else if (m_phase == 3 && ng) begin
      model_clear();
    end
  endtask

  task automatic step(input bit bv, input int r, input bit wk, input bit ex,
                      input bit ni, input bit ng, input bit rst, input string lbl);
    exp_t e;
    @(negedge clk);
    reset = rst; ball_valid = bv; runs_in = 3'(r); wicket_in = wk;
    extra_in = ex; next_inning = ni; new_game = ng;
    model(bv, r, wk, ex, ni, ng, rst);
    e.r = m_runs; e.w = m_wk; e.o = m_legal / 6; e.b = m_legal % 6;
    e.io = (m_phase == 1); e.go = (m_phase == 3); e.win = m_win; e.tie = m_tie;
    e.lbl = lbl;
    exp_q.push_back(e);
  endtask

  task automatic ball(input int r, input bit wk, input bit ex, input string lbl);
    step(1'b1, r, wk, ex, 1'b0, 1'b0, 1'b0, lbl);
  endtask
  task automatic do_reset(input string lbl);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lbl);
  endtask
  task automatic pulse_ni(input string lbl);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, lbl);
  endtask
  task automatic pulse_ng(input string lbl);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, lbl);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (binaryruns !== 8'(e.r) || binarywickets !== 4'(e.w) || overs !== 5'(e.o) ||
            balls !== 3'(e.b) || inningOver !== e.io || gameOver !== e.go ||
            winner !== e.win || tie !== e.tie) begin
          n_fail++;
          $display("FAIL %s: got runs=%0d wk=%0d ov=%0d b=%0d io=%b go=%b win=%b tie=%b, expected runs=%0d wk=%0d ov=%0d b=%0d io=%b go=%b win=%b tie=%b",
                   e.lbl, binaryruns, binarywickets, overs, balls, inningOver, gameOver,
                   winner, tie, e.r, e.w, e.o, e.b, e.io, e.go, e.win, e.tie);
        end
      end
    end
  end

  initial begin
    do_reset("reset_state");
    // Delivery coincident with reset must be ignored.
    step(1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "ball_during_reset");

    // Extras: three wides then a legal four.
    repeat (3) ball(0, 1'b0, 1'b1, "wide");
    ball(4, 1'b0, 1'b0, "legal_after_wides");

    // Overs limit with MAX_OVERS=2.
    do_reset("reset_overs");
    for (int i = 0; i < 12; i++) ball(1, 1'b0, 1'b0, "overs_limit_ball");
    ball(6, 1'b1, 1'b0, "ball_in_break");
    pulse_ng("new_game_in_break");
    pulse_ni("next_inning");
    ball(6, 1'b0, 1'b0, "chase_6a");
    ball(6, 1'b0, 1'b0, "chase_6b");
    ball(1, 1'b0, 1'b0, "chase_win");
    ball(3, 1'b0, 1'b0, "ball_in_done");
    pulse_ni("next_inning_in_done");
    pulse_ng("new_game");

    // All out.
    for (int i = 0; i < 10; i++) ball(2, 1'b1, 1'b0, "all_out_ball");
    pulse_ni("next_inning_tie");
    for (int i = 0; i < 12; i++) ball((i < 10) ? 2 : 0, 1'b0, 1'b0, "tie_chase");
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "tie_hold");
    pulse_ng("new_game_after_tie");

    // Exact tie with 12 runs each.
    for (int i = 0; i < 12; i++) ball(1, 1'b0, 1'b0, "inn1_12");
    pulse_ni("ni_tie12");
    for (int i = 0; i < 12; i++) ball(1, 1'b0, 1'b0, "inn2_12");

    // Saturation: clamped 7 as wides adds 7 per delivery, legal 7 adds 6.
    do_reset("reset_sat");
    ball(7, 1'b0, 1'b0, "legal_clamp");
    for (int i = 0; i < 40; i++) ball(7, 1'b0, 1'b1, "saturate");

    // Chase win coinciding with tenth wicket.
    do_reset("reset_prio");
    for (int i = 0; i < 10; i++) ball(0, 1'b1, 1'b0, "inn1_duck");
    pulse_ni("ni_prio");
    for (int i = 0; i < 9; i++) ball(0, 1'b1, 1'b0, "inn2_wkts");
    ball(1, 1'b1, 1'b0, "win_on_last_wicket");

    // Reset mid second innings, then stray controls in INN1.
    do_reset("reset_mid2_prep");
    ball(3, 1'b0, 1'b0, "prep");
    for (int i = 0; i < 9; i++) ball(1, 1'b1, 1'b0, "prep_w");
    ball(0, 1'b1, 1'b0, "prep_out");
    pulse_ni("ni_mid2");
    ball(4, 1'b1, 1'b0, "inn2_progress");
    do_reset("reset_mid_inn2");
    pulse_ng("new_game_in_inn1");
    pulse_ni("next_inning_in_inn1");

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) < 75), int'($urandom_range(7)), ($urandom_range(99) < 12),
           ($urandom_range(99) < 15), ($urandom_range(99) < 10),
           ($urandom_range(99) < 10), ($urandom_range(999) < 5), "random");
    end

    @(negedge clk);
    reset = 1'b0; ball_valid = 1'b0; next_inning = 1'b0; new_game = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/innings_controller.md
INNINGS_CONTROLLER -- requirements
Module: innings_controller

Interface
REQ-001 SHALL have parameter MAX_OVERS, default 20, legal overs per innings (1..31).
REQ-002 SHALL have port clk_fpga  input  1  100 MHz master clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ball_valid  input  1  single-cycle pulse; one delivery is presented.
REQ-005 SHALL have port runs_in  input  3  runs scored on the delivery, sampled with ball_valid.
REQ-006 SHALL have port wicket_in  input  1  delivery takes a wicket, sampled with ball_valid.
REQ-007 SHALL have port extra_in  input  1  wide/no-ball, sampled with ball_valid.
REQ-008 SHALL have port next_inning  input  1  single-cycle pulse; starts innings 2 from BREAK.
REQ-009 SHALL have port new_game  input  1  single-cycle pulse; restarts from DONE.
REQ-010 SHALL have port binaryruns  output  8  displayed run total.
REQ-011 SHALL have port binarywickets  output  4  displayed wicket count (0..10).
REQ-012 SHALL have port overs  output  5  completed overs of the current innings.
REQ-013 SHALL have port balls  output  3  legal balls in the current over (0..5).
REQ-014 SHALL have port inningOver  output  1  high in BREAK.
REQ-015 SHALL have port gameOver  output  1  high in DONE.
REQ-016 SHALL have port winner  output  1  0 = team 1, 1 = team 2; valid while gameOver.
REQ-017 SHALL have port tie  output  1  scores level at end; valid while gameOver.

Function
REQ-018 SHALL implement states INN1, BREAK, INN2, DONE; all outputs registered.
REQ-019 SHALL process a delivery only when ball_valid=1 in INN1 or INN2; ignored in BREAK/DONE.
REQ-020 SHALL clamp runs_in above 6 to 6.
REQ-021 SHALL add runs_in to innings runs for a legal ball; runs_in+1 for an extra.
REQ-022 SHALL saturate run totals at 255 (no wrap).
REQ-023 SHALL increment wickets by 1 when wicket_in=1, including on an extra; runs and wicket of the same delivery both apply.
REQ-024 SHALL advance balls only on legal balls; at balls=5 a legal ball sets balls=0 and increments overs.
REQ-025 SHALL show all delivery effects on outputs the cycle after ball_valid (1-cycle latency).
REQ-026 SHALL move INN1->BREAK on the delivery producing wickets=10 or overs=MAX_OVERS; inningOver high the next cycle.
REQ-027 SHALL, in BREAK, hold innings-1 runs/wickets/overs/balls on the outputs.
REQ-028 SHALL, on next_inning in BREAK, enter INN2 with displayed runs, wickets, overs, balls all 0, and store innings-1 runs as the target base.
REQ-029 SHALL move INN2->DONE on the delivery making runs2 > runs1: winner=1, tie=0.
REQ-030 SHALL otherwise move INN2->DONE on wickets=10 or overs=MAX_OVERS: tie=1/winner=0 if runs2=runs1, else winner=0/tie=0.
REQ-031 SHALL give the chase-win condition priority when it coincides with a wickets/overs limit on the same delivery.
REQ-032 SHALL, in DONE, hold innings-2 figures and winner/tie until new_game or reset.
REQ-033 SHALL, on new_game in DONE, enter INN1 with every counter and flag cleared; new_game ignored in other states.
REQ-034 SHALL ignore next_inning outside BREAK.

Reset
REQ-035 SHALL on reset immediately enter INN1 with binaryruns=0, binarywickets=0, overs=0, balls=0, inningOver=0, gameOver=0, winner=0, tie=0, stored target cleared.
REQ-036 SHALL abandon any innings in progress when reset asserts mid-game; a delivery coincident with reset deassertion is ignored.

Verification
REQ-037 SHALL cover MAX_OVERS=2: 12 legal balls runs_in=1 -> after 12th, inningOver=1, binaryruns=12, overs=2, balls=0.
REQ-038 SHALL cover extras: 3 wides runs_in=0 then 1 legal runs_in=4 -> binaryruns=7, balls=1, overs=0.
REQ-039 SHALL cover all-out: 10 legal balls wicket_in=1, runs_in=2 -> binarywickets=10, binaryruns=20, inningOver=1.
REQ-040 SHALL cover chase: innings1=12, next_inning, balls of 6,6,1 -> gameOver=1, winner=1, binaryruns=13 after 3rd ball.
REQ-041 SHALL cover tie and saturation: innings1=12, innings2 ends at 12 -> tie=1, winner=0; separately runs_in=7 repeated to 255 -> clamps at 6/ball, total holds 255.
REQ-042 SHALL cover reset mid-INN2 -> all outputs zero next edge, state INN1; new_game/next_inning in INN1 -> no effect.
